// File: rtl/wb_regfile_stage_if.sv
// Writeback-stage bundle: W-stage control and data coming out of the MEM/WB
// registers, the two Decode read ports, and the values the stage returns.
//   master : whoever drives the W slot and the Decode read addresses
//   slave  : the writeback/register-file stage itself
// Signals
//   ValidW, RegWriteW, ResultSrcW, Funct3W, RdW    W-stage control
//   ALUResultW, ReadDataW, PCPlus4W, ImmExtW       W-stage result candidates
//   Rs1D, Rs2D                                     Decode read addresses
//   RD1D, RD2D                                     Decode read data
//   ResultW                                        selected writeback value
//   InstretW                                       retired-instruction count
interface wb_regfile_stage_if #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int CNT_WIDTH = 64
);
    localparam int IDX_W = $clog2(NREG);

    logic                 ValidW;
    logic                 RegWriteW;
    logic [1:0]           ResultSrcW;
    logic [2:0]           Funct3W;
    logic [IDX_W-1:0]     RdW;
    logic [XLEN-1:0]      ALUResultW;
    logic [XLEN-1:0]      ReadDataW;
    logic [XLEN-1:0]      PCPlus4W;
    logic [XLEN-1:0]      ImmExtW;
    logic [IDX_W-1:0]     Rs1D;
    logic [IDX_W-1:0]     Rs2D;
    logic [XLEN-1:0]      RD1D;
    logic [XLEN-1:0]      RD2D;
    logic [XLEN-1:0]      ResultW;
    logic [CNT_WIDTH-1:0] InstretW;

    modport master (
        output ValidW, RegWriteW, ResultSrcW, Funct3W, RdW,
        output ALUResultW, ReadDataW, PCPlus4W, ImmExtW,
        output Rs1D, Rs2D,
        input  RD1D, RD2D, ResultW, InstretW
    );

    modport slave (
        input  ValidW, RegWriteW, ResultSrcW, Funct3W, RdW,
        input  ALUResultW, ReadDataW, PCPlus4W, ImmExtW,
        input  Rs1D, Rs2D,
        output RD1D, RD2D, ResultW, InstretW
    );
endinterface

// File: rtl/wb_regfile_stage.sv
// Writeback stage with the integer register file.
// Selects the W-stage result (ALU / aligned load / PC+4 / immediate), writes
// it to the NREG x XLEN register file, serves two combinational Decode read
// ports with same-cycle write-through bypass and counts retired instructions.
// Ports
//   clk  rising-edge clock
//   rst  synchronous reset, active-high: clears every register and the counter
//   bus  wb_regfile_stage_if.slave (W-stage inputs, read ports, ResultW, InstretW)
module wb_regfile_stage #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int CNT_WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    wb_regfile_stage_if.slave  bus
);

    logic [XLEN-1:0]      regs [NREG];
    logic [XLEN-1:0]      load_data;
    logic [XLEN-1:0]      result;
    logic                 we;
    logic [CNT_WIDTH-1:0] instret_p0;

    // Extract and extend the addressed byte/halfword of the raw memory word.
    // Halfword selection uses only off[1]; a misaligned lh/lhu is not trapped.
    function automatic logic [XLEN-1:0] align_load(
        input logic [2:0]      f3,
        input logic [1:0]      off,
        input logic [XLEN-1:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[16 +: 16] : word[0 +: 16];
        case (f3)
            3'b000:  return {{(XLEN-8){b[7]}}, b};
            3'b100:  return {{(XLEN-8){1'b0}}, b};
            3'b001:  return {{(XLEN-16){h[15]}}, h};
            3'b101:  return {{(XLEN-16){1'b0}}, h};
            default: return word;
        endcase
    endfunction

    assign load_data = align_load(bus.Funct3W, bus.ALUResultW[1:0], bus.ReadDataW);

    always_comb begin
        result = bus.ALUResultW;
        case (bus.ResultSrcW)
            2'b00:   result = bus.ALUResultW;
            2'b01:   result = load_data;
            2'b10:   result = bus.PCPlus4W;
            default: result = bus.ImmExtW;
        endcase
    end

    assign bus.ResultW = result;

    // x0 is never a write target, so it can never be bypassed either.
    assign we = bus.ValidW & bus.RegWriteW & (bus.RdW != '0) & ~rst;

    always_comb begin
        bus.RD1D = '0;
        if (!rst) begin
            if (we && (bus.Rs1D == bus.RdW)) begin
                bus.RD1D = result;
            end else if (bus.Rs1D != '0) begin
                bus.RD1D = regs[bus.Rs1D];
            end
        end
    end

    always_comb begin
        bus.RD2D = '0;
        if (!rst) begin
            if (we && (bus.Rs2D == bus.RdW)) begin
                bus.RD2D = result;
            end else if (bus.Rs2D != '0) begin
                bus.RD2D = regs[bus.Rs2D];
            end
        end
    end

    // ---- register file / retire counter update (1 edge) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            instret_p0 <= '0;
        end else begin
            if (we) begin
                regs[bus.RdW] <= result;
            end
            // Retires regardless of RegWriteW; wraps modulo 2^CNT_WIDTH.
            if (bus.ValidW) begin
                instret_p0 <= instret_p0 + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.InstretW = instret_p0;

endmodule

// File: tb/tb_wb_regfile_stage.sv
module tb_wb_regfile_stage;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wb_regfile_stage_if #(.XLEN(32), .NREG(32), .CNT_WIDTH(64)) bus ();
    wb_regfile_stage_if #(.XLEN(32), .NREG(32), .CNT_WIDTH(4))  bus4 ();

    wb_regfile_stage #(.XLEN(32), .NREG(32), .CNT_WIDTH(64)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    wb_regfile_stage #(.XLEN(32), .NREG(32), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4.slave)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_instret = '0;

    task automatic idle();
        bus.ValidW     = 1'b0;
        bus.RegWriteW  = 1'b0;
        bus.ResultSrcW = 2'b00;
        bus.Funct3W    = 3'b010;
        bus.RdW        = 5'd0;
        bus.ALUResultW = '0;
        bus.ReadDataW  = '0;
        bus.PCPlus4W   = '0;
        bus.ImmExtW    = '0;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] rdat,
                         input logic [31:0] pc4, input logic [31:0] imm);
        bus.ValidW     = v;
        bus.RegWriteW  = rw;
        bus.ResultSrcW = src;
        bus.Funct3W    = f3;
        bus.RdW        = rd;
        bus.ALUResultW = alu;
        bus.ReadDataW  = rdat;
        bus.PCPlus4W   = pc4;
        bus.ImmExtW    = imm;
        if (v && !rst) exp_instret = exp_instret + 64'd1;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] val, input string name);
        exp_t e;
        e.rd = rd; e.val = val; e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.Rs1D = 5'd5; bus.Rs2D = 5'd5;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (bus.RD1D !== 32'h0) begin n_err++; $display("FAIL reset_rd1: got %h want %h", bus.RD1D, 32'h0); end
        n_cmp++;
        if (bus.InstretW !== 64'h0) begin n_err++; $display("FAIL reset_instret: got %0d want 0", bus.InstretW); end
        // bypass suppressed while in reset
        drive(1, 1, 2'b00, 3'b010, 5'd5, 32'h55, 0, 0, 0);
        #1;
        n_cmp++;
        if (bus.RD1D !== 32'h0) begin n_err++; $display("FAIL reset_nobypass: got %h want %h", bus.RD1D, 32'h0); end
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 2'b00, 3'b010, 5'd5, 32'h11, 0, 0, 0);
        @(negedge clk);
        idle();
        bus.Rs1D = 5'd5;
        #1;
        n_cmp++;
        if (bus.RD1D !== 32'h11) begin n_err++; $display("FAIL pre_reset_x5: got %h want %h", bus.RD1D, 32'h11); end
        // instruction sitting in W on the reset edge is dropped
        rst = 1'b1;
        drive(1, 1, 2'b00, 3'b010, 5'd6, 32'h66, 0, 0, 0);
        exp_instret = '0;
        @(negedge clk);
        rst = 1'b0;
        idle();
        bus.Rs1D = 5'd5; bus.Rs2D = 5'd6;
        #1;
        n_cmp++;
        if (bus.RD1D !== 32'h0) begin n_err++; $display("FAIL reset_clears_x5: got %h want %h", bus.RD1D, 32'h0); end
        n_cmp++;
        if (bus.RD2D !== 32'h0) begin n_err++; $display("FAIL reset_drops_x6: got %h want %h", bus.RD2D, 32'h0); end
        n_cmp++;
        if (bus.InstretW !== exp_instret) begin n_err++; $display("FAIL reset_instret2: got %0d want %0d", bus.InstretW, exp_instret); end
    endtask

    task automatic test_x0();
        @(negedge clk);
        drive(1, 1, 2'b00, 3'b010, 5'd0, 32'hDEADBEEF, 0, 0, 0);
        bus.Rs1D = 5'd0; bus.Rs2D = 5'd0;
        #1;
        n_cmp++;
        if (bus.RD1D !== 32'h0) begin n_err++; $display("FAIL x0_nobypass: got %h want %h", bus.RD1D, 32'h0); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++;
        if (bus.RD1D !== 32'h0) begin n_err++; $display("FAIL x0_read: got %h want %h", bus.RD1D, 32'h0); end
        n_cmp++;
        if (bus.InstretW !== 64'd1) begin n_err++; $display("FAIL x0_instret: got %0d want 1", bus.InstretW); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        drive(1, 1, 2'b00, 3'b010, 5'd7, 32'h1234, 0, 0, 0);
        bus.Rs1D = 5'd7; bus.Rs2D = 5'd7;
        #1;
        n_cmp++;
        if (bus.ResultW !== 32'h1234) begin n_err++; $display("FAIL bypass_result: got %h want %h", bus.ResultW, 32'h1234); end
        n_cmp++;
        if (bus.RD1D !== 32'h1234) begin n_err++; $display("FAIL bypass_rd1: got %h want %h", bus.RD1D, 32'h1234); end
        n_cmp++;
        if (bus.RD2D !== 32'h1234) begin n_err++; $display("FAIL bypass_rd2: got %h want %h", bus.RD2D, 32'h1234); end
        @(negedge clk);
        drive(1, 0, 2'b00, 3'b010, 5'd7, 32'h9999, 0, 0, 0);
        #1;
        n_cmp++;
        if (bus.RD1D !== 32'h1234) begin n_err++; $display("FAIL bypass_after_rd1: got %h want %h", bus.RD1D, 32'h1234); end
        n_cmp++;
        if (bus.RD2D !== 32'h1234) begin n_err++; $display("FAIL bypass_after_rd2: got %h want %h", bus.RD2D, 32'h1234); end
        @(negedge clk);
        drive(0, 1, 2'b00, 3'b010, 5'd7, 32'h5555, 0, 0, 0);
        #1;
        n_cmp++;
        if (bus.RD1D !== 32'h1234) begin n_err++; $display("FAIL bubble_nobypass: got %h want %h", bus.RD1D, 32'h1234); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++;
        if (bus.RD2D !== 32'h1234) begin n_err++; $display("FAIL bypass_bubble_nowrite: got %h want %h", bus.RD2D, 32'h1234); end
        n_cmp++;
        if (bus.InstretW !== exp_instret) begin n_err++; $display("FAIL bypass_instret: got %0d want %0d", bus.InstretW, exp_instret); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3  [11] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b010, 3'b100,
                                  3'b001, 3'b101, 3'b000, 3'b011, 3'b100};
        logic [1:0]  off [11] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd0, 2'd3,
                                  2'd3, 2'd0, 2'd0, 2'd1, 2'd2};
        logic [31:0] exv [11] = '{32'h0000007F, 32'hFFFFFF80, 32'h000000FF, 32'hFFFF80FF,
                                  32'h80FF7F01, 32'h00000080, 32'hFFFF80FF, 32'h00007F01,
                                  32'h00000001, 32'h80FF7F01, 32'h000000FF};
        exp_t e;
        // lhu off2 -> 0x000080FF from the reference table
        f3[2] = 3'b101; exv[2] = 32'h000080FF;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(1, 1, 2'b01, f3[i], 5'(8 + i), {30'h400, off[i]}, 32'h80FF7F01,
                  32'h11111111, 32'h22222222);
            #1;
            n_cmp++;
            if (bus.ResultW !== exv[i]) begin
                n_err++;
                $display("FAIL load_result[%0d] f3=%b off=%0d: got %h want %h", i, f3[i], off[i], bus.ResultW, exv[i]);
            end
            push(5'(8 + i), exv[i], $sformatf("load_reg[%0d]", i));
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk);
            idle();
            bus.Rs1D = e.rd;
            #1;
            n_cmp++;
            if (bus.RD1D !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, bus.RD1D, e.val); end
        end
    endtask

    task automatic test_result_mux();
        exp_t e;
        @(negedge clk);
        drive(1, 1, 2'b10, 3'b010, 5'd20, 32'hAAAA0001, 32'hBBBB0002, 32'h10000008, 32'hCCCC0003);
        #1;
        n_cmp++;
        if (bus.ResultW !== 32'h10000008) begin n_err++; $display("FAIL mux_pc4: got %h want %h", bus.ResultW, 32'h10000008); end
        push(5'd20, 32'h10000008, "mux_pc4_reg");
        @(negedge clk);
        drive(1, 1, 2'b11, 3'b010, 5'd21, 32'hAAAA0001, 32'hBBBB0002, 32'hDDDD0004, 32'hABCDE000);
        #1;
        n_cmp++;
        if (bus.ResultW !== 32'hABCDE000) begin n_err++; $display("FAIL mux_imm: got %h want %h", bus.ResultW, 32'hABCDE000); end
        push(5'd21, 32'hABCDE000, "mux_imm_reg");
        @(negedge clk);
        drive(1, 1, 2'b00, 3'b000, 5'd22, 32'hCAFEF00D, 32'hBBBB0002, 32'hDDDD0004, 32'hEEEE0005);
        #1;
        n_cmp++;
        if (bus.ResultW !== 32'hCAFEF00D) begin n_err++; $display("FAIL mux_alu: got %h want %h", bus.ResultW, 32'hCAFEF00D); end
        push(5'd22, 32'hCAFEF00D, "mux_alu_reg");
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk);
            idle();
            bus.Rs2D = e.rd;
            #1;
            n_cmp++;
            if (bus.RD2D !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, bus.RD2D, e.val); end
        end
    endtask

    task automatic test_bubble();
        logic [63:0] cnt_before;
        @(negedge clk);
        drive(1, 1, 2'b00, 3'b010, 5'd3, 32'h33, 0, 0, 0);
        @(negedge clk);
        cnt_before = exp_instret;
        drive(0, 1, 2'b00, 3'b010, 5'd3, 32'h99, 0, 0, 0);
        bus.Rs1D = 5'd3;
        #1;
        n_cmp++;
        if (bus.RD1D !== 32'h33) begin n_err++; $display("FAIL bubble_comb: got %h want %h", bus.RD1D, 32'h33); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++;
        if (bus.RD1D !== 32'h33) begin n_err++; $display("FAIL bubble_x3: got %h want %h", bus.RD1D, 32'h33); end
        n_cmp++;
        if (bus.InstretW !== cnt_before) begin n_err++; $display("FAIL bubble_instret: got %0d want %0d", bus.InstretW, cnt_before); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1, 1, 2'b00, 3'b010, 5'(10 + i), vals[i], 0, 0, 0);
            bus.Rs1D = 5'(10 + i);
            if (i > 0) bus.Rs2D = 5'(9 + i);
            #1;
            n_cmp++;
            if (bus.RD1D !== vals[i]) begin n_err++; $display("FAIL b2b_bypass[%0d]: got %h want %h", i, bus.RD1D, vals[i]); end
            if (i > 0) begin
                n_cmp++;
                if (bus.RD2D !== vals[i-1]) begin n_err++; $display("FAIL b2b_prev[%0d]: got %h want %h", i, bus.RD2D, vals[i-1]); end
            end
            push(5'(10 + i), vals[i], $sformatf("b2b_reg[%0d]", i));
        end
        @(negedge clk);
        drive(1, 1, 2'b00, 3'b010, 5'd14, 32'h1, 0, 0, 0);
        @(negedge clk);
        drive(1, 1, 2'b00, 3'b010, 5'd14, 32'h2, 0, 0, 0);
        push(5'd14, 32'h2, "b2b_overwrite");
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk);
            idle();
            bus.Rs1D = e.rd;
            #1;
            n_cmp++;
            if (bus.RD1D !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, bus.RD1D, e.val); end
        end
        n_cmp++;
        if (bus.InstretW !== exp_instret) begin n_err++; $display("FAIL b2b_instret: got %0d want %0d", bus.InstretW, exp_instret); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        rst = 1'b1;
        idle();
        bus4.ValidW = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus4.ValidW = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        n_cmp++;
        if (bus4.InstretW !== 4'd15) begin n_err++; $display("FAIL wrap_15: got %0d want 15", bus4.InstretW); end
        @(negedge clk);
        bus4.ValidW = 1'b0;
        bus4.RegWriteW = 1'b1;
        #1;
        n_cmp++;
        if (bus4.InstretW !== 4'd0) begin n_err++; $display("FAIL wrap_16: got %0d want 0", bus4.InstretW); end
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (bus4.InstretW !== 4'd0) begin n_err++; $display("FAIL wrap_bubble: got %0d want 0", bus4.InstretW); end
        n_cmp++;
        if (bus.InstretW !== 64'd0) begin n_err++; $display("FAIL wrap_main_idle: got %0d want 0", bus.InstretW); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        bus.Rs1D = '0; bus.Rs2D = '0;
        bus4.ValidW = 1'b0; bus4.RegWriteW = 1'b0; bus4.ResultSrcW = '0; bus4.Funct3W = '0;
        bus4.RdW = '0; bus4.ALUResultW = '0; bus4.ReadDataW = '0; bus4.PCPlus4W = '0;
        bus4.ImmExtW = '0; bus4.Rs1D = '0; bus4.Rs2D = '0;
        test_reset();
        test_x0();
        test_bypass();
        test_loads();
        test_result_mux();
        test_bubble();
        test_back_to_back();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
